// File: rtl/esc_pkg.sv
// esc_pkg: shared constants and helpers for the ESC pulse generator.
//   DEFAULT_* : default timing constants (50 MHz clk, 400 Hz frame,
//               1000..2000 us pulse range).
//   clamp_width(sum_us, max_us) : limit a requested pulse width to max_us.
package esc_pkg;

  localparam int DEFAULT_CLK_PER_US = 50;
  localparam int DEFAULT_FRAME_US   = 2500;
  localparam int DEFAULT_MIN_US     = 1000;
  localparam int DEFAULT_MAX_US     = 2000;

  // The caller forms sum_us = MIN_US + command at a width that cannot
  // overflow, so a plain compare against max_us is enough here.
  function automatic logic [31:0] clamp_width(input logic [31:0] sum_us,
                                               input logic [31:0] max_us);
    return (sum_us > max_us) ? max_us : sum_us;
  endfunction

endpackage

// File: rtl/us_tick.sv
// us_tick: free-running prescaler producing one tick per microsecond.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (count returns to 0)
//   tick  : high for exactly one clk while the count is CLK_PER_US-1;
//           the count wraps to 0 on the following edge.
module us_tick
  import esc_pkg::*;
#(
  parameter int CLK_PER_US = DEFAULT_CLK_PER_US
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  // A 1-clk-per-us configuration still needs a 1-bit counter.
  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_US - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/esc_multi.sv
// esc_multi: multi-channel ESC/servo pulse generator.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   arm         : 1 = use commanded widths, 0 = force MIN_US everywhere;
//                 sampled only at frame boundaries
//   wr_en       : one-clk write strobe into the shadow command registers
//   wr_ch       : channel index for the write (>= CHANNELS is ignored)
//   wr_val      : command; pulse width = MIN_US + wr_val us, clamped
//   sig         : registered active-high pulse outputs
//   frame_start : one-clk pulse at each frame boundary
//   armed       : arm value latched for the current frame
//
// Write interface: wr_en is a bare strobe with no ready. Every strobed
// write to a valid channel is accepted on the edge it is presented and
// lands in the shadow register; it reaches the output only when the
// next frame boundary copies shadow into the active width. A write on
// the boundary edge itself is therefore seen one frame later.
module esc_multi
  import esc_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int VAL_BITS   = 10,
  parameter int CLK_PER_US = DEFAULT_CLK_PER_US,
  parameter int FRAME_US   = DEFAULT_FRAME_US,
  parameter int MIN_US     = DEFAULT_MIN_US,
  parameter int MAX_US     = DEFAULT_MAX_US
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                wr_en,
  input  logic [3:0]          wr_ch,
  input  logic [VAL_BITS-1:0] wr_val,
  output logic [CHANNELS-1:0] sig,
  output logic                frame_start,
  output logic                armed
);

  // us counter width; active widths share it because MAX_US < FRAME_US.
  localparam int UW = $clog2(FRAME_US);
  // MIN_US + command is formed one bit wider than either operand.
  localparam int MAX_LOG = $clog2(MAX_US);
  localparam int SUM_W = ((VAL_BITS > MAX_LOG) ? VAL_BITS : MAX_LOG) + 1;

  localparam logic [UW-1:0] US_LAST = UW'(FRAME_US - 1);
  localparam logic [UW-1:0] MIN_W   = UW'(MIN_US);

  if (MAX_US >= FRAME_US) begin : g_bad_max
    $fatal(1, "esc_multi: MAX_US must be below FRAME_US");
  end
  if (MIN_US > MAX_US) begin : g_bad_min
    $fatal(1, "esc_multi: MIN_US must not exceed MAX_US");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_ch
    $fatal(1, "esc_multi: CHANNELS must be 1..16");
  end

  logic          tick;
  logic [UW-1:0] us_cnt;
  logic          frame_wrap;

  us_tick #(
    .CLK_PER_US(CLK_PER_US)
  ) u_us_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // The boundary is the edge on which us_cnt wraps; everything latched
  // per frame (armed, active widths) updates on that same edge.
  assign frame_wrap = tick && (us_cnt == US_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt      <= '0;
      frame_start <= 1'b0;
      armed       <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        us_cnt <= '0;
        armed  <= arm;
      end else if (tick) begin
        us_cnt <= us_cnt + UW'(1);
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [VAL_BITS-1:0] shadow;
    logic [SUM_W-1:0]    sum_us;
    logic [UW-1:0]       active;
    logic [UW-1:0]       active_nxt;
    logic                sig_q;

    assign sum_us     = SUM_W'(MIN_US) + SUM_W'(shadow);
    assign active_nxt = arm ? UW'(clamp_width(32'(sum_us), 32'(MAX_US)))
                            : MIN_W;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow <= '0;
        active <= MIN_W;
        sig_q  <= 1'b0;
      end else begin
        // Indices >= CHANNELS match no channel, so they fall away here.
        if (wr_en && (wr_ch == 4'(i))) begin
          shadow <= wr_val;
        end
        // Reads the pre-edge shadow, so a coincident write waits a frame.
        if (frame_wrap) begin
          active <= active_nxt;
        end
        sig_q <= (us_cnt < active);
      end
    end

    assign sig[i] = sig_q;
  end

endmodule

// File: tb/tb_esc_multi.sv
// tb_esc_multi: directed and randomized frames for esc_multi, scaled to a
// short frame (2 clk/us, 250 us frame, 100..200 us pulses). The reference
// model tracks the shadow commands, the latched arm and the per-frame
// widths in microseconds; each frame the bench measures every channel's
// leading high run, the frame_start position and armed.
module tb_esc_multi;

  localparam int CH   = 4;
  localparam int VB   = 10;
  localparam int CPU  = 2;
  localparam int FUS  = 250;
  localparam int MINU = 100;
  localparam int MAXU = 200;
  localparam int FC   = CPU * FUS;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          arm    = 1'b0;
  logic          wr_en  = 1'b0;
  logic [3:0]    wr_ch  = '0;
  logic [VB-1:0] wr_val = '0;
  logic [CH-1:0] sig;
  logic          frame_start;
  logic          armed;

  esc_multi #(
    .CHANNELS  (CH),
    .VAL_BITS  (VB),
    .CLK_PER_US(CPU),
    .FRAME_US  (FUS),
    .MIN_US    (MINU),
    .MAX_US    (MAXU)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_val     (wr_val),
    .sig        (sig),
    .frame_start(frame_start),
    .armed      (armed)
  );

  // clock
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // reference model state
  int exp_shadow[CH];
  int exp_width[CH];
  bit exp_armed;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      exp_shadow[c] = 0;
      exp_width[c]  = MINU;
    end
    exp_armed = 1'b0;
  endtask

  // Frame boundary: disarmed frames run at minimum, armed ones at
  // MIN + command limited to MAX.
  task automatic model_latch();
    for (int c = 0; c < CH; c++) begin
      if (arm) exp_width[c] = (MINU + exp_shadow[c] > MAXU) ? MAXU : MINU + exp_shadow[c];
      else     exp_width[c] = MINU;
    end
    exp_armed = arm;
  endtask

  // One full frame. Positions are edges 1..FC within the frame; edge FC
  // is the boundary into the next frame. wr_pos / arm_pos of 0 = none.
  task automatic run_frame(input string name, input int wr_pos, input int ch,
                           input int val, input int arm_pos, input bit arm_v);
    int run[CH];
    bit gap[CH];
    int cur_w[CH];
    bit cur_armed;
    int fs_cnt;
    int fs_pos;
    logic [31:0] armed_mid;
    fs_cnt = 0;
    fs_pos = 0;
    armed_mid = '0;
    cur_armed = exp_armed;
    for (int c = 0; c < CH; c++) begin
      run[c]   = 0;
      gap[c]   = 1'b0;
      cur_w[c] = exp_width[c];
    end
    for (int p = 1; p <= FC; p++) begin
      if (p == arm_pos) arm = arm_v;
      if (p == wr_pos) begin
        wr_en  = 1'b1;
        wr_ch  = 4'(ch);
        wr_val = VB'(val);
      end
      @(posedge clk);
      if (p == FC) model_latch();
      if (wr_en && wr_ch < CH) exp_shadow[int'(wr_ch)] = int'(wr_val);
      @(negedge clk);
      wr_en = 1'b0;
      for (int c = 0; c < CH; c++) begin
        if (sig[c] === 1'b1) begin
          if (gap[c]) run[c] += FC;  // a second pulse poisons the width
          else        run[c]++;
        end else begin
          gap[c] = 1'b1;
        end
      end
      if (frame_start === 1'b1) begin
        fs_cnt++;
        fs_pos = p;
      end
      if (p == FC / 2) armed_mid = 32'(armed);
    end
    for (int c = 0; c < CH; c++)
      check($sformatf("%s ch%0d width_clks", name, c), 32'(run[c]), 32'(cur_w[c] * CPU));
    check({name, " frame_start_pos"}, (fs_cnt == 1) ? 32'(fs_pos) : 32'(0), 32'(FC));
    check({name, " armed"}, armed_mid, 32'(cur_armed));
  endtask

  initial begin
    model_reset();

    // reset state while held in reset
    #12;
    check("reset sig", 32'(sig), 32'(0));
    check("reset frame_start", 32'(frame_start), 32'(0));
    check("reset armed", 32'(armed), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // idle, disarmed
    run_frame("idle0", 0, 0, 0, 0, 1'b0);
    run_frame("idle1", 0, 0, 0, 0, 1'b0);
    // arm and command ch0 -> 150 us from the next frame
    run_frame("arm_wr0", 20, 0, 50, 10, 1'b1);
    // ch0 shows 150 us; command ch1 past the clamp
    run_frame("ch0_wide", 30, 1, 1023, 0, 1'b0);
    // ch1 clamped at 200 us; write ch2 mid-pulse at us_cnt=80
    run_frame("ch1_clamp", 161, 2, 20, 0, 1'b0);
    // ch2 now 120 us; write ch3 on the boundary edge
    run_frame("ch2_new_wr3_edge", FC, 3, 30, 0, 1'b0);
    // ch3 still old width; drop arm mid-frame
    run_frame("ch3_old_disarm", 0, 0, 0, 200, 1'b0);
    // all minimum, armed=0; re-arm early
    run_frame("disarmed_rearm", 0, 0, 0, 5, 1'b1);
    // ch3 130 us; out-of-range write
    run_frame("ch3_new_wr7", 100, 7, 5, 0, 1'b0);
    run_frame("after_wr7", 0, 0, 0, 0, 1'b0);

    // reset in the middle of a pulse
    repeat (60) @(negedge clk);
    check("pre_reset sig high", 32'(sig), 32'({CH{1'b1}}));
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset sig", 32'(sig), 32'(0));
    check("mid_reset armed", 32'(armed), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_frame("post_rst0", 0, 0, 0, 0, 1'b0);
    run_frame("post_rst1", 0, 0, 0, 0, 1'b0);

    // randomized frames
    for (int f = 0; f < 20; f++) begin
      int wp, wc, wv, ap;
      bit av;
      wp = $urandom_range(0, FC);
      wc = $urandom_range(0, 7);
      wv = $urandom_range(0, 1023);
      ap = $urandom_range(0, FC);
      av = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rand%0d", f), wp, wc, wv, ap, av);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/esc_multi.md
Name: esc_multi

Overview:
- Multi-channel ESC/servo pulse generator; successor to the single-channel ESC driver.
- Generates CHANNELS synchronous PWM outputs with a shared frame period and a built-in 1 µs prescaler, so no external timer is needed.
- Per-channel commands are double-buffered and take effect only at frame boundaries, so no output ever shows a runt pulse.
- An arm/disarm gate forces all channels to minimum throttle; it sits between the flight-control command logic and the FPGA ESC pins.

Parameters:
- CHANNELS, 4: number of ESC outputs (1..16).
- VAL_BITS, 10: width of a per-channel command value.
- CLK_PER_US, 50: clk cycles per microsecond (50 MHz clk).
- FRAME_US, 2500: frame period in µs (400 Hz).
- MIN_US, 1000: pulse width at zero command and when disarmed.
- MAX_US, 2000: maximum pulse width; commands are clamped to this.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  level; 1 = use commanded values, 0 = force MIN_US on all channels.
- wr_en  in  1  single-cycle write strobe for the shadow command register.
- wr_ch  in  4  target channel index for the write.
- wr_val  in  VAL_BITS  command value; pulse width = MIN_US + wr_val µs, clamped.
- sig  out  CHANNELS  ESC pulse outputs, active high.
- frame_start  out  1  one-clk pulse at the start of each frame.
- armed  out  1  arm state latched for the current frame.

Behaviour:
- Reset (async assert, rst_n=0):
  - sig=0, frame_start=0, armed=0.
  - Prescaler and µs counter are 0.
  - All shadow registers are 0.
  - All active widths are MIN_US.
- Prescaler:
  - Counts 0..CLK_PER_US-1.
  - tick=1 for exactly one clk when the count equals CLK_PER_US-1; the count then wraps to 0.
- µs counter:
  - us_cnt advances on tick over the range 0..FRAME_US-1.
  - When tick occurs with us_cnt=FRAME_US-1, us_cnt wraps to 0 and the frame boundary fires.
- Frame boundary (same clk edge as the wrap):
  - frame_start pulses for 1 clk.
  - armed <= arm.
  - For each channel i: active[i] <= arm ? min(MIN_US + shadow[i], MAX_US) : MIN_US.
- Output:
  - sig[i] is registered: sig[i] <= (us_cnt < active[i]). Each output therefore lags its comparison by 1 clk.
  - After reset release, the first frame starts immediately at us_cnt=0 with MIN_US pulses. frame_start does not fire for this first frame; it first fires at the first wrap.
- Pulse width: exactly active[i]*CLK_PER_US clks.
- Period: exactly FRAME_US*CLK_PER_US clks.
- Width/arithmetic:
  - The clamp sum is computed at width max(VAL_BITS, clog2(MAX_US)) + 1 so it cannot overflow.
  - us_cnt width is clog2(FRAME_US).
- Writes:
  - When wr_en=1 and wr_ch < CHANNELS, shadow[wr_ch] <= wr_val.
  - When wr_ch >= CHANNELS, the write is silently ignored.
  - Writes never affect the current frame.
- Write coincident with frame boundary: the latch uses the old shadow value; the new value applies from the next frame.
- arm changes mid-frame: take effect only at the next boundary; the current pulses complete unchanged.
- Reset mid-frame: all outputs drop to 0 asynchronously; on release, the post-reset state above applies.
- Elaboration checks:
  - MAX_US < FRAME_US.
  - MIN_US <= MAX_US.
  - CHANNELS <= 16.
  - Any violation stops elaboration.

Decomposition:
- Package esc_pkg holds:
  - default timing constants (MIN_US, MAX_US, FRAME_US, CLK_PER_US);
  - a function computing the clamped width.
- Sub-module us_tick holds the prescaler (param CLK_PER_US; ports clk, rst_n, tick).
- The channel compare/latch logic is a generate loop inside esc_multi.

Test Plan:
- Reset then idle, arm=0 → every sig high for 50000 clks (1000 µs), period 125000 clks; frame_start pulses every 125000 clks; armed=0.
- arm=1, write ch0=500 → the frame after the next boundary shows a ch0 pulse of 75000 clks (1500 µs); other channels stay at 50000 clks.
- Write ch1=1023 while armed → ch1 pulse clamps to 100000 clks (2000 µs), never longer.
- Write ch2=200 mid-pulse at us_cnt=800 → the current ch2 pulse stays at the previous width; the new 1200 µs width appears only from the next frame.
- Write coincident with frame_start (ch3=300) → that frame uses the old ch3 value; the next frame shows 1300 µs. Drop arm mid-frame → the current frame completes normally and the next frame is all 1000 µs with armed=0.
- wr_ch=7 with CHANNELS=4 → no channel width changes. Assert rst_n=0 mid-pulse → sig=0 immediately; after release all sig are 1000 µs.
